// File: rtl/regfile_mp_if.sv
// Bundle of the regfile_mp write, scoreboard, read and clear-sweep signals.
// master drives requests into the file; slave is the register file itself.
interface regfile_mp_if #(
   parameter int s_width = 32,
   parameter int s_index = 5,
   parameter int n_read  = 2
);
   logic                        load0;
   logic [s_index-1:0]          dest0;
   logic [s_width-1:0]          in0;
   logic                        load1;
   logic [s_index-1:0]          dest1;
   logic [s_width-1:0]          in1;
   logic                        reserve;
   logic [s_index-1:0]          reserve_dest;
   logic [n_read*s_index-1:0]   src;
   logic [n_read*s_width-1:0]   rdata;
   logic [n_read-1:0]           pending;
   logic                        clear_req;
   logic                        clear_busy;

   modport master (
      output load0, dest0, in0, load1, dest1, in1,
      output reserve, reserve_dest, src, clear_req,
      input  rdata, pending, clear_busy
   );

   modport slave (
      input  load0, dest0, in0, load1, dest1, in1,
      input  reserve, reserve_dest, src, clear_req,
      output rdata, pending, clear_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with writeback scoreboard and sequential clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
   parameter int s_width = 32,
   parameter int s_index = 5,
   parameter int n_read  = 2
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);

   localparam int                 NUM_REGS = 2**s_index;
   localparam logic [s_index-1:0] LAST_IDX = '1;
   localparam logic [s_index-1:0] ONE_IDX  = s_index'(1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t               r_state;
   logic [s_index-1:0]   r_cnt;
   logic [s_width-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]  r_pend;

   logic w_busy;
   logic w_we0;
   logic w_we1;
   logic w_rsv;

   // Index 0 is hardwired, and all updates are suppressed while sweeping.
   assign w_busy = (r_state == CLEAR);
   assign w_we0  = bus.load0   && (bus.dest0        != '0) && !w_busy && !rst;
   assign w_we1  = bus.load1   && (bus.dest1        != '0) && !w_busy && !rst;
   assign w_rsv  = bus.reserve && (bus.reserve_dest != '0) && !w_busy && !rst;

   assign bus.clear_busy = w_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         // Later assignments win: port 1 over port 0, reserve over write-clear.
         if (w_we0) begin
            r_regs[bus.dest0] <= bus.in0;
            r_pend[bus.dest0] <= 1'b0;
         end
         if (w_we1) begin
            r_regs[bus.dest1] <= bus.in1;
            r_pend[bus.dest1] <= 1'b0;
         end
         if (w_rsv) begin
            r_pend[bus.reserve_dest] <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (bus.clear_req) begin
                  r_state <= CLEAR;
                  r_cnt   <= ONE_IDX;
                  r_pend  <= '0;
               end
            end
            CLEAR: begin
               r_regs[r_cnt] <= '0;
               if (r_cnt == LAST_IDX) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + ONE_IDX;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   for (genvar k = 0; k < n_read; k++) begin : g_rd
      logic [s_index-1:0] w_idx;
      logic [s_width-1:0] w_data;
      logic               w_pnd;

      assign w_idx = bus.src[k*s_index +: s_index];

      always_comb begin
         w_data = r_regs[w_idx];
         w_pnd  = r_pend[w_idx];
`ifdef REGFILE_BYPASS_EN
         if (w_we1 && (bus.dest1 == w_idx)) begin
            w_data = bus.in1;
            w_pnd  = w_rsv && (bus.reserve_dest == w_idx);
         end else if (w_we0 && (bus.dest0 == w_idx)) begin
            w_data = bus.in0;
            w_pnd  = w_rsv && (bus.reserve_dest == w_idx);
         end
`endif
         if (w_idx == '0) begin
            w_data = '0;
            w_pnd  = 1'b0;
         end
      end

      assign bus.rdata[k*s_width +: s_width] = w_data;
      assign bus.pending[k]                  = w_pnd;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: writes, scoreboard, clear sweep, reset abort, bypass.
module tb_regfile_mp;

   logic clk;
   logic rst;
   int   ncmp;
   int   nfail;
   int   n;

   regfile_mp_if #(.s_width(32), .s_index(5), .n_read(2)) bus ();

   regfile_mp #(.s_width(32), .s_index(5), .n_read(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] i0, input logic [4:0] i1);
      bus.src = {i1, i0};
      #1;
   endtask

   task automatic fill_all();
      for (int i = 1; i < 32; i++) begin
         bus.load0 = 1'b1;
         bus.dest0 = 5'(i);
         bus.in0   = 32'hC000_0000 + 32'(i);
         tick();
      end
      bus.load0 = 1'b0;
   endtask

   initial begin
      ncmp = 0;
      nfail = 0;
      rst = 1'b1;
      bus.load0 = 1'b0; bus.dest0 = '0; bus.in0 = '0;
      bus.load1 = 1'b0; bus.dest1 = '0; bus.in1 = '0;
      bus.reserve = 1'b0; bus.reserve_dest = '0;
      bus.src = '0; bus.clear_req = 1'b0;
      tick();
      tick();
      rd(5'd5, 5'd31);
      check("rst_rdata",   bus.rdata[63:0], 64'h0);
      check("rst_pending", 32'(bus.pending), 32'h0);
      check("rst_busy",    32'(bus.clear_busy), 32'h0);
      rst = 1'b0;
      tick();

      // Basic write/read
      bus.load0 = 1'b1; bus.dest0 = 5'd5; bus.in0 = 32'hDEADBEEF;
      tick();
      bus.load0 = 1'b0;
      rd(5'd5, 5'd0);
      check("r5_data", bus.rdata[31:0], 32'hDEADBEEF);
      check("r5_pend", 32'(bus.pending[0]), 32'h0);

      // Dual write collision and r0 immunity
      bus.load0 = 1'b1; bus.dest0 = 5'd7; bus.in0 = 32'h11;
      bus.load1 = 1'b1; bus.dest1 = 5'd7; bus.in1 = 32'h22;
      tick();
      bus.load1 = 1'b0;
      bus.dest0 = 5'd0; bus.in0 = 32'hFFFF;
      tick();
      bus.load0 = 1'b0;
      rd(5'd7, 5'd0);
      check("r7_port1_wins", bus.rdata[31:0], 32'h22);
      check("r0_data",       bus.rdata[63:32], 32'h0);

      // Scoreboard
      bus.reserve = 1'b1; bus.reserve_dest = 5'd3;
      tick();
      bus.reserve = 1'b0;
      rd(5'd0, 5'd3);
      check("r3_reserved", 32'(bus.pending[1]), 32'h1);
      bus.load1 = 1'b1; bus.dest1 = 5'd3; bus.in1 = 32'h5;
      tick();
      bus.load1 = 1'b0;
      rd(5'd0, 5'd3);
      check("r3_wb_pend", 32'(bus.pending[1]), 32'h0);
      check("r3_wb_data", bus.rdata[63:32], 32'h5);
      bus.reserve = 1'b1; bus.reserve_dest = 5'd3;
      bus.load0 = 1'b1; bus.dest0 = 5'd3; bus.in0 = 32'h6;
      tick();
      bus.reserve = 1'b0; bus.load0 = 1'b0;
      rd(5'd0, 5'd3);
      check("r3_rsv_wins", 32'(bus.pending[1]), 32'h1);
      check("r3_rsv_data", bus.rdata[63:32], 32'h6);
      bus.reserve = 1'b1; bus.reserve_dest = 5'd0;
      tick();
      bus.reserve = 1'b0;
      rd(5'd0, 5'd0);
      check("r0_rsv_pend", 32'(bus.pending[0]), 32'h0);

      // Full clear sweep with writes/reserves dropped during it
      fill_all();
      rd(5'd31, 5'd1);
      check("fill_r31", bus.rdata[31:0],  32'hC000_001F);
      check("fill_r1",  bus.rdata[63:32], 32'hC000_0001);
      bus.reserve = 1'b1; bus.reserve_dest = 5'd3;
      tick();
      bus.clear_req = 1'b1; bus.reserve = 1'b0;
      tick();
      bus.clear_req = 1'b0;
      bus.load0 = 1'b1; bus.dest0 = 5'd5; bus.in0 = 32'h999;
      bus.reserve = 1'b1; bus.reserve_dest = 5'd6;
      n = 0;
      while (bus.clear_busy && n < 40) begin
         n++;
         tick();
      end
      bus.load0 = 1'b0; bus.reserve = 1'b0;
      check("sweep_cycles", 32'(n), 32'd31);
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(i));
         check($sformatf("swept_r%0d", i), bus.rdata[31:0], 32'h0);
         check($sformatf("swept_pend%0d", i), 32'(bus.pending), 32'h0);
      end

      // Reset in the middle of a sweep
      fill_all();
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("busy_before_rst", 32'(bus.clear_busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_busy_imm", 32'(bus.clear_busy), 32'h0);
      rd(5'd20, 5'd31);
      check("rst_r20", bus.rdata[31:0],  32'h0);
      check("rst_r31", bus.rdata[63:32], 32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", 32'(bus.clear_busy), 32'h0);
      for (int i = 1; i < 32; i++) begin
         rd(5'(i), 5'd0);
         check($sformatf("rst_r%0d", i), bus.rdata[31:0], 32'h0);
      end
      bus.load0 = 1'b1; bus.dest0 = 5'd4; bus.in0 = 32'h1234;
      tick();
      bus.load0 = 1'b0;
      rd(5'd4, 5'd0);
      check("post_rst_write", bus.rdata[31:0], 32'h1234);

      // Same-cycle write/read
      bus.load0 = 1'b1; bus.dest0 = 5'd9; bus.in0 = 32'hA5;
      rd(5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
      check("bypass_r9", bus.rdata[63:32], 32'hA5);
`else
      check("bypass_r9", bus.rdata[63:32], 32'h0);
`endif
      check("bypass_pend", 32'(bus.pending[1]), 32'h0);
      tick();
      bus.load0 = 1'b0;
      rd(5'd0, 5'd9);
      check("r9_next", bus.rdata[63:32], 32'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter s_width, default 32, data width of each register.
REQ-002 Parameter s_index, default 5, register index width; num_regs = 2**s_index.
REQ-003 Parameter n_read, default 2, number of read ports (1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; the block SHALL use one clock, and reset is asynchronous and active-high.
REQ-006 load0 / dest0 / in0  input  1 / s_index / s_width  write port 0: enable, index, data.
REQ-007 load1 / dest1 / in1  input  1 / s_index / s_width  write port 1: enable, index, data.
REQ-008 reserve / reserve_dest  input  1 / s_index  scoreboard: mark register as pending a writeback.
REQ-009 src  input  n_read*s_index  read indices, port k at bits [k*s_index +: s_index].
REQ-010 rdata  output  n_read*s_width  read data, port k at bits [k*s_width +: s_width].
REQ-011 pending  output  n_read  scoreboard bit of each read port's source register.
REQ-012 clear_req  input  1  request a sequential zeroing sweep of the file.
REQ-013 clear_busy  output  1  high while the sweep runs.

Function
REQ-014 Register 0 SHALL always read as 0 with pending 0; writes and reserves to index 0 SHALL be ignored.
REQ-015 Reads SHALL be combinational from src; writes SHALL take effect at the next rising edge.
REQ-016 Both write ports enabled to the same nonzero dest in one cycle: port 1 value SHALL be stored, port 0 dropped.
REQ-017 A write to register r SHALL clear pending[r]; reserve SHALL set pending[reserve_dest].
REQ-018 Reserve and write to the same register in one cycle: pending SHALL end set (reserve wins).
REQ-019 FSM states IDLE and CLEAR; IDLE->CLEAR on clear_req; CLEAR->IDLE after index num_regs-1 is zeroed.
REQ-020 On IDLE->CLEAR edge all pending bits SHALL clear and the sweep counter SHALL load 1.
REQ-021 In CLEAR, one register per cycle SHALL be zeroed at the counter index, counter +1; the sweep takes num_regs-1 cycles.
REQ-022 clear_busy SHALL equal (state == CLEAR); clear_req while busy SHALL be ignored.
REQ-023 While clear_busy, load0, load1 and reserve SHALL be dropped; reads remain valid.
REQ-024 Counter SHALL be s_index bits; no wrap past num_regs-1 (terminates exactly there).

Reset
REQ-025 rst high SHALL immediately zero every register, every pending bit, the sweep counter, and force IDLE.
REQ-026 rst asserted mid-sweep SHALL abort it; after deassertion clear_busy = 0 and all reads = 0.
REQ-027 Outputs during and after reset: rdata = 0, pending = 0, clear_busy = 0.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL enable write-to-read forwarding.
REQ-029 Defined: a read of a nonzero register being written this cycle SHALL return the incoming data (port 1 priority over port 0), pending for it 0 unless also reserved.
REQ-030 Undefined: such a read SHALL return the old stored value and old pending bit; new value visible next cycle.

Verification
REQ-031 Reset then write r5=0xDEADBEEF via port 0, next cycle src0=5 -> rdata port 0 = 0xDEADBEEF, pending 0.
REQ-032 Both ports write r7 (port0 0x11, port1 0x22) -> r7 reads 0x22; write r0=0xFFFF -> r0 reads 0.
REQ-033 reserve r3, then port 1 writes r3=0x5 -> pending 1 then 0; reserve+write r3 same cycle -> pending 1.
REQ-034 Fill r1..r31, pulse clear_req -> clear_busy high exactly 31 cycles, writes during sweep dropped, all reads 0 after.
REQ-035 Assert rst at sweep cycle 10 -> clear_busy 0 immediately, all registers 0, new writes accepted after release.
REQ-036 With REGFILE_BYPASS_EN, write r9=0xA5 and read src1=9 same cycle -> rdata port 1 = 0xA5; without it -> old value 0.
